// File: rtl/mips_boot_loader.sv
// UART (8N1) boot loader: writes a framed, checksummed image into mips_sys memory and holds the system in reset until it is accepted.
// Latency: mem_we one cycle after the 4th byte of a word; backpressure: none, the serial line cannot be stalled.
module mips_boot_loader #(
    parameter int          CLK_DIV  = 434,
    parameter int          ADDR_W   = 12,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              sys_rst_o,
    output logic              boot_done,
    output logic              boot_err
);

    localparam int              CNT_W     = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [32:0]      MAX_WORDS = 33'd1 << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_WAIT_HDR, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
    } state_t;

    // ---------------- receive line synchroniser ----------------
    logic rxd_s1_q, rxd_s2_q, rxd_s3_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_s1_q <= 1'b1;
            rxd_s2_q <= 1'b1;
            rxd_s3_q <= 1'b1;
        end else begin
            rxd_s1_q <= boot_rxd;
            rxd_s2_q <= rxd_s1_q;
            rxd_s3_q <= rxd_s2_q;
        end
    end

    // ---------------- bit sampler ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_vld_q, byte_vld_d;
    logic             frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 1'b1;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rxd_s3_q && !rxd_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // mid-start re-check rejects glitches shorter than half a bit
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_LAST) begin
                    rx_cnt_d    = '0;
                    byte_vld_d  = rxd_s2_q;
                    frame_err_d = !rxd_s2_q;
                    rx_state_d  = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              mem_we_q, mem_we_d;
    logic              boot_done_q, boot_done_d;
    logic              boot_err_q, boot_err_d;
    logic              sys_rst_q, sys_rst_d;
    logic [15:0]       n_words;
    logic              last_word;

    assign n_words   = {len_q[15:8], rx_shift_q};
    assign last_word = ({{(33-ADDR_W){1'b0}}, mem_addr_q} == ({17'd0, len_q} - 33'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_WAIT_HDR;
            len_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            byte_cnt_q  <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
            sys_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_cnt_q  <= byte_cnt_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
            sys_rst_q   <= sys_rst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        byte_cnt_d  = byte_cnt_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        boot_done_d = boot_done_q;
        boot_err_d  = boot_err_q;
        sys_rst_d   = (state_q == S_RUN);
        // the address steps after each pulse except the final word, which leaves DATA
        if (mem_we_q && state_q == S_DATA) mem_addr_d = mem_addr_q + 1'b1;
        if (frame_err_q && state_q != S_RUN && state_q != S_WAIT_HDR) begin
            state_d    = S_ERROR;
            boot_err_d = 1'b1;
        end else if (byte_vld_q) begin
            case (state_q)
                S_WAIT_HDR, S_ERROR: begin
                    if (rx_shift_q == HDR_BYTE) begin
                        state_d    = S_LEN_HI;
                        boot_err_d = 1'b0;
                    end
                end
                S_LEN_HI: begin
                    len_d   = {rx_shift_q, 8'h00};
                    state_d = S_LEN_LO;
                end
                S_LEN_LO: begin
                    len_d      = n_words;
                    mem_addr_d = '0;
                    byte_cnt_d = '0;
                    sum_d      = '0;
                    if ({17'd0, n_words} > MAX_WORDS) begin
                        state_d    = S_ERROR;
                        boot_err_d = 1'b1;
                    end else if (n_words == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    mem_wdata_d = {mem_wdata_q[23:0], rx_shift_q};
                    sum_d       = sum_q + rx_shift_q;
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d = 1'b1;
                        if (last_word) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_shift_q == sum_q) begin
                        state_d     = S_RUN;
                        boot_done_d = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        boot_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign sys_rst_o = sys_rst_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader with CLK_DIV=4, ADDR_W=4.
module tb_mips_boot_loader;

    localparam int CLK_DIV = 4;
    localparam int ADDR_W  = 4;

    logic              clk;
    logic              rst;
    logic              boot_rxd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              sys_rst_o;
    logic              boot_done;
    logic              boot_err;

    int total = 0;
    int bad   = 0;
    int wide_pulses = 0;
    int base;
    logic prev_we = 1'b0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];

    logic [7:0] frame_a [12] = '{8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h12,
                                 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h83};

    mips_boot_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .HDR_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_rxd  (boot_rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .sys_rst_o (sys_rst_o),
        .boot_done (boot_done),
        .boot_err  (boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (prev_we) wide_pulses++;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        boot_rxd = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            boot_rxd = b[i];
            bit_time();
        end
        boot_rxd = stop;
        bit_time();
        boot_rxd = 1'b1;
        bit_time();
        bit_time();
    endtask

    task automatic send_frame_a(input logic [7:0] csum);
        for (int i = 0; i < 11; i++) send_byte(frame_a[i], 1'b1);
        send_byte(csum, 1'b1);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b0;
        boot_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we",    32'(mem_we),    32'd0);
        check("rst_addr",  32'(mem_addr),  32'd0);
        check("rst_wdata", mem_wdata,      32'd0);
        check("rst_sys",   32'(sys_rst_o), 32'd0);
        check("rst_done",  32'(boot_done), 32'd0);
        check("rst_err",   32'(boot_err),  32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // good two-word image
        base = wr_addr.size();
        send_frame_a(8'h83);
        check("a_wr_count", 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            check("a_addr0", 32'(wr_addr[base]),   32'd0);
            check("a_data0", wr_data[base],        32'h3C011234);
            check("a_addr1", 32'(wr_addr[base+1]), 32'd1);
            check("a_data1", wr_data[base+1],      32'h00000000);
        end
        check("a_sys", 32'(sys_rst_o), 32'd1);
        check("a_done", 32'(boot_done), 32'd1);
        check("a_err", 32'(boot_err), 32'd0);

        // wrong checksum, then recovery with the correct frame
        do_reset();
        send_frame_a(8'h84);
        check("csum_err",  32'(boot_err),  32'd1);
        check("csum_sys",  32'(sys_rst_o), 32'd0);
        check("csum_done", 32'(boot_done), 32'd0);
        send_byte(8'hA5, 1'b1);
        check("retry_err_clr", 32'(boot_err), 32'd0);
        for (int i = 1; i < 12; i++) send_byte(frame_a[i], 1'b1);
        repeat (6) @(negedge clk);
        check("retry_done", 32'(boot_done), 32'd1);
        check("retry_sys",  32'(sys_rst_o), 32'd1);

        // zero-length image
        do_reset();
        base = wr_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (6) @(negedge clk);
        check("zero_wr_count", 32'(wr_addr.size() - base), 32'd0);
        check("zero_done", 32'(boot_done), 32'd1);
        check("zero_err",  32'(boot_err),  32'd0);

        // 17 words exceeds a 16-word memory
        do_reset();
        base = wr_addr.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        repeat (6) @(negedge clk);
        check("len_err",      32'(boot_err),  32'd1);
        check("len_done",     32'(boot_done), 32'd0);
        check("len_wr_count", 32'(wr_addr.size() - base), 32'd0);

        // single-cycle low glitch between length bytes must not form a byte
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        boot_rxd = 1'b0;
        @(negedge clk);
        boot_rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_err",  32'(boot_err),  32'd0);
        check("glitch_done", 32'(boot_done), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (6) @(negedge clk);
        check("glitch_then_done", 32'(boot_done), 32'd1);

        // stop bit low on the second data byte
        do_reset();
        base = wr_addr.size();
        for (int i = 0; i < 4; i++) send_byte(frame_a[i], 1'b1);
        send_byte(frame_a[4], 1'b0);
        repeat (6) @(negedge clk);
        check("stop_err",      32'(boot_err),  32'd1);
        check("stop_sys",      32'(sys_rst_o), 32'd0);
        check("stop_wr_count", 32'(wr_addr.size() - base), 32'd0);

        // asynchronous reset after five data bytes, then a clean reload
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(frame_a[i], 1'b1);
        check("mid_addr_pre",  32'(mem_addr), 32'd1);
        check("mid_wdata_pre", mem_wdata,     32'h01123400);
        rst = 1'b0;
        #1;
        check("mid_we",    32'(mem_we),    32'd0);
        check("mid_addr",  32'(mem_addr),  32'd0);
        check("mid_wdata", mem_wdata,      32'd0);
        check("mid_sys",   32'(sys_rst_o), 32'd0);
        check("mid_done",  32'(boot_done), 32'd0);
        check("mid_err",   32'(boot_err),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        base = wr_addr.size();
        send_frame_a(8'h83);
        check("reload_wr_count", 32'(wr_addr.size() - base), 32'd2);
        if (wr_addr.size() >= base + 2) begin
            check("reload_addr0", 32'(wr_addr[base]),   32'd0);
            check("reload_data0", wr_data[base],        32'h3C011234);
            check("reload_addr1", 32'(wr_addr[base+1]), 32'd1);
            check("reload_data1", wr_data[base+1],      32'h00000000);
        end
        check("reload_done", 32'(boot_done), 32'd1);
        check("we_pulse_width", 32'(wide_pulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_boot_loader.md
Name: mips_boot_loader

Overview:
- Serial boot loader sitting directly upstream of the mips_sys top.
- Receives a framed program image over a dedicated UART line (8N1) and writes it word-by-word into the instruction/data memory that serves zz_ins_i/zz_din.
- Holds the processor system in reset (drives its rst) until a complete, checksum-valid image is loaded, then releases it.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (>= 4).
- ADDR_W, 12, word-address width of target memory; capacity 2^ADDR_W words.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- boot_rxd  input  1  UART receive line, asynchronous, idle high.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  word address of the current write.
- mem_wdata  output  32  write data, big-endian assembled.
- sys_rst_o  output  1  active-low reset to mips_sys; low while loading.
- boot_done  output  1  high once the image is accepted.
- boot_err  output  1  high after a framing, length or checksum error.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, sys_rst_o=0, boot_done=0, boot_err=0; FSM=WAIT_HDR; rx sampler idle.
- RX synchroniser: boot_rxd passes through a 2-FF synchroniser; the synchronised signal resets to 1.
- RX sampler, start detect: a falling edge starts a bit counter. At CLK_DIV/2 cycles the line is re-checked; if high, it is a false start and the sampler returns to idle with no byte.
- RX sampler, data bits: 8 data bits are sampled LSB first, each CLK_DIV cycles apart.
- RX sampler, stop bit: the stop bit is sampled CLK_DIV after the last data bit. If 1, a one-cycle byte_valid is raised. If 0, a one-cycle frame_err is raised.
- RX sampler, re-arm: the sampler re-arms immediately after the stop sample.
- Frame format: HDR_BYTE, LEN_HI, LEN_LO (N = word count, 16 bits), then N*4 data bytes MSB first, then CSUM = 8-bit sum of all data bytes mod 256.
- WAIT_HDR: a byte equal to HDR_BYTE goes to LEN_HI and clears boot_err. Other bytes are ignored.
- LEN_HI -> LEN_LO on the next byte.
- LEN_LO: if N > 2^ADDR_W, go to ERROR. If N == 0, go to CSUM. Otherwise go to DATA with mem_addr=0, byte_cnt=0, sum=0.
- DATA: each byte shifts into mem_wdata and is added to sum.
  - On the 4th byte of a word, mem_we pulses exactly one cycle, in the cycle after that byte_valid.
  - mem_addr increments in the cycle after the pulse. It never exceeds N-1 during a write and does not wrap.
  - After word N, go to CSUM.
- CSUM: if the byte equals sum, go to RUN. Otherwise go to ERROR.
- RUN: boot_done=1, and sys_rst_o rises to 1 in the cycle after entry. Further bytes and frame errors are ignored until rst.
- ERROR: boot_err=1, sys_rst_o stays 0. An HDR_BYTE restarts at LEN_HI with boot_err cleared; other bytes are ignored.
- frame_err in any state except RUN and WAIT_HDR goes to ERROR. In WAIT_HDR, frame_err is ignored.
- Simultaneous events: byte_valid and frame_err are mutually exclusive by construction. mem_we never coincides with a state change other than DATA->CSUM.
- Reset mid-load: asynchronous; all state returns to reset values immediately. Memory already written is left as is.

Test Plan:
- CLK_DIV=4, ADDR_W=4, frame A5 00 02 3C 01 12 34 00 00 00 00 83:
  - mem_we pulses twice: addr 0 with data 32'h3C011234, then addr 1 with data 32'h00000000.
  - sys_rst_o=1 and boot_done=1 after the checksum byte; boot_err=0.
- Same frame with checksum 84 -> boot_err=1, sys_rst_o=0, boot_done=0. Resending the correct frame -> boot_err=0, then boot_done=1.
- Frame A5 00 00 00 -> no mem_we; boot_done=1.
- Length A5 00 11 with ADDR_W=4 (17 > 16) -> boot_err=1; no writes.
- Stop bit forced low on the 2nd data byte -> boot_err=1; a 1-cycle low glitch on an idle line produces no byte and no state change.
- rst asserted after 5 data bytes -> all outputs return to reset values immediately; a following full valid frame loads correctly from addr 0.
